// File: rtl/ahb_slave_mem_ws.sv
// AHB-Lite slave with an internal word RAM, programmable read/write wait states and
// same-word read-after-write forwarding. Define AHB_SLAVE_ERR_EN to enable ERROR responses.
module ahb_slave_mem_ws #(
  parameter int SLAVE_NUM = 0,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 16,
  parameter int DEPTH     = 1024,
  parameter int RD_WAIT   = 1,
  parameter int WR_WAIT   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  output logic [DATA_W-1:0] HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int          LB    = $clog2(NB);
  localparam int          IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_ERR1 = 3'd3;
  localparam logic [2:0] ST_ERR2 = 3'd4;

  logic [2:0]        state;
  logic [3:0]        cnt;
  logic              d_write;
  logic [IDX_W-1:0]  d_word;
  logic [NB-1:0]     d_strb;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              acc;
  logic              a_err;
  logic [ADDR_W-1:0] a_full;
  logic [IDX_W-1:0]  a_word;
  logic [2:0]        a_size;
  logic [LB-1:0]     a_mask;
  logic [NB-1:0]     a_strb;
  logic [3:0]        a_wait;
  int unsigned       a_first;
  int unsigned       a_nbytes;

  logic              wr_commit;
  logic              rd_load;
  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_W-1:0] rd_data;

  logic              unused;
  assign unused = ^{HTRANS[0], 32'(SLAVE_NUM)};

  assign acc       = HSEL & HREADY & HTRANS[1] & HREADYOUT;
  assign HREADYOUT = !((state == ST_WAIT) || (state == ST_ERR1));
  assign wr_commit = (state == ST_DATA) && d_write;
  assign a_wait    = HWRITE ? 4'(WR_WAIT) : 4'(RD_WAIT);

  // Address-phase decode: clamped size, lane strobes and word index.
  always_comb begin
    a_size   = (HSIZE > 3'(LB)) ? 3'(LB) : HSIZE;
    a_mask   = LB'((32'd1 << a_size) - 32'd1);
    a_first  = 32'(HADDR[LB-1:0] & ~a_mask);
    a_nbytes = 32'd1 << a_size;
    a_full   = HADDR >> LB;
    a_strb   = '0;
    for (int unsigned i = 0; i < NB; i++)
      a_strb[i] = (i >= a_first) && (i < a_first + a_nbytes);
`ifdef AHB_SLAVE_ERR_EN
    a_word = IDX_W'(a_full);
    a_err  = (int'(a_full) >= DEPTH) || (HSIZE > 3'(LB)) || ((HADDR[LB-1:0] & a_mask) != '0);
`else
    a_word = IDX_W'(32'(a_full) % 32'(DEPTH));
    a_err  = 1'b0;
`endif
  end

  // HRDATA is registered, so the RAM is read on the edge entering the completing cycle;
  // a write committing on that same edge is merged in to avoid returning stale bytes.
  always_comb begin
    rd_load = 1'b0;
    rd_idx  = a_word;
    if (acc && !a_err && !HWRITE && (RD_WAIT == 0)) begin
      rd_load = 1'b1;
    end else if ((state == ST_WAIT) && (cnt == 4'd1) && !d_write) begin
      rd_load = 1'b1;
      rd_idx  = d_word;
    end
    rd_data = mem[rd_idx];
    if (wr_commit && (rd_idx == d_word)) begin
      for (int unsigned i = 0; i < NB; i++)
        if (d_strb[i]) rd_data[8*i +: 8] = HWDATA[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      d_write <= 1'b0;
      d_word  <= '0;
      d_strb  <= '0;
      HRDATA  <= '0;
    end else begin
      if (rd_load) HRDATA <= rd_data;
      case (state)
        ST_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= ST_DATA;
        end
        ST_ERR1: state <= ST_ERR2;
        default: begin
          if (acc) begin
            d_write <= HWRITE;
            d_word  <= a_word;
            d_strb  <= a_strb;
            if (a_err) begin
              state <= ST_ERR1;
            end else if (a_wait != 4'd0) begin
              state <= ST_WAIT;
              cnt   <= a_wait;
            end else begin
              state <= ST_DATA;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_commit) begin
      for (int unsigned i = 0; i < NB; i++)
        if (d_strb[i]) mem[d_word][8*i +: 8] <= HWDATA[8*i +: 8];
    end
  end

`ifdef AHB_SLAVE_ERR_EN
  assign HRESP = (state == ST_ERR1) || (state == ST_ERR2);
`else
  assign HRESP = 1'b0;
`endif

endmodule
